// File: rtl/nand_tree_pkg.sv
// Op encoding and decode helpers shared by the NAND-family reduction tree.
// Ops split into a combine rule (AND vs OR) and an optional final inversion.
package nand_tree_pkg;

    localparam logic [1:0] OP_NAND = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_NOR  = 2'b10;
    localparam logic [1:0] OP_OR   = 2'b11;

    function automatic logic is_inverting(input logic [1:0] op);
        return !op[0];
    endfunction

    function automatic logic uses_or(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/nand_tree_stage.sv
// One registered tree level: pairwise AND/OR of N words into N/2, inverting on FINAL.
// Latency 1 cycle; accepts whenever empty or downstream ready, otherwise holds.
module nand_tree_stage
    import nand_tree_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter bit FINAL = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_vld,
    input  logic [N*WIDTH-1:0]       i_dat,
    input  logic [1:0]               i_op,
    output logic                     o_rdy,
    input  logic                     i_rdy,
    output logic                     o_vld,
    output logic [(N/2)*WIDTH-1:0]   o_dat,
    output logic [1:0]               o_op
);

    localparam int M = N / 2;

    logic [M*WIDTH-1:0] w_comb;
    logic [M*WIDTH-1:0] r_dat;
    logic [1:0]         r_op;
    logic               r_vld;

    always_comb begin
        w_comb = '0;
        for (int j = 0; j < M; j++) begin
            if (uses_or(i_op)) begin
                w_comb[j*WIDTH +: WIDTH] = i_dat[(2*j)*WIDTH +: WIDTH] | i_dat[(2*j+1)*WIDTH +: WIDTH];
            end else begin
                w_comb[j*WIDTH +: WIDTH] = i_dat[(2*j)*WIDTH +: WIDTH] & i_dat[(2*j+1)*WIDTH +: WIDTH];
            end
        end
        // Inverting here keeps out_data a plain register output.
        if (FINAL && is_inverting(i_op)) begin
            w_comb = ~w_comb;
        end
    end

    assign o_rdy = !r_vld || i_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_dat <= '0;
            r_op  <= OP_NAND;
        end else if (o_rdy) begin
            r_vld <= i_vld;
            r_dat <= w_comb;
            r_op  <= i_op;
        end
    end

    assign o_vld = r_vld;
    assign o_dat = r_dat;
    assign o_op  = r_op;

endmodule

// File: rtl/nand_tree_pipe.sv
// Streaming INPUTS-operand bitwise NAND/AND/NOR/OR reduction, log2(INPUTS) registered levels.
// One result per cycle; in_ready is the combinational ready chain back from out_ready.
module nand_tree_pipe
    import nand_tree_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int INPUTS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INPUTS*WIDTH-1:0] in_data,
    input  logic [1:0]              in_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data
);

    localparam int S  = $clog2(INPUTS);
    localparam int NW = 2*INPUTS - 1;

    if (INPUTS < 2 || (INPUTS & (INPUTS - 1)) != 0) begin : g_chk_inputs
        $error("nand_tree_pipe: INPUTS must be a power of two >= 2");
    end

    // Word offset of level k in the flattened tree bus (level 0 is the operand set).
    function automatic int word_off(input int k);
        return 2*INPUTS - 2*(INPUTS >> k);
    endfunction

    logic [NW*WIDTH-1:0] w_tree;
    logic [S:0]          w_vld;
    logic [1:0]          w_op [0:S];
    logic [S+1:1]        w_rdy;
    logic                w_unused_op;

    assign w_tree[INPUTS*WIDTH-1:0] = in_data;
    assign w_vld[0]   = in_valid;
    assign w_op[0]    = in_op;
    assign w_rdy[S+1] = out_ready;
    assign in_ready   = w_rdy[1];

    for (genvar k = 1; k <= S; k++) begin : g_lvl
        nand_tree_stage #(
            .WIDTH (WIDTH),
            .N     (INPUTS >> (k-1)),
            .FINAL (k == S)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .i_vld (w_vld[k-1]),
            .i_dat (w_tree[word_off(k-1)*WIDTH +: (INPUTS >> (k-1))*WIDTH]),
            .i_op  (w_op[k-1]),
            .o_rdy (w_rdy[k]),
            .i_rdy (w_rdy[k+1]),
            .o_vld (w_vld[k]),
            .o_dat (w_tree[word_off(k)*WIDTH +: (INPUTS >> k)*WIDTH]),
            .o_op  (w_op[k])
        );
    end

    assign out_valid   = w_vld[S];
    assign out_data    = w_tree[word_off(S)*WIDTH +: WIDTH];
    assign w_unused_op = ^w_op[S];

endmodule

// File: tb/tb_nand_tree_pipe.sv
// Directed bench for nand_tree_pipe: a 4x8 instance with a scoreboard plus a 2x8 instance.
module tb_nand_tree_pipe;
    import nand_tree_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [31:0] a_in_data = '0;
    logic [1:0]  a_in_op = 2'b00;
    logic        a_out_valid;
    logic        a_out_ready = 1'b1;
    logic [7:0]  a_out_data;

    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [15:0] b_in_data = '0;
    logic [1:0]  b_in_op = 2'b00;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [7:0]  b_out_data;

    int n_vec = 0;
    int n_err = 0;
    int n_push = 0;
    int n_pop = 0;
    int n_stall = 0;
    logic [7:0] sb_q [$];

    always #5 clk = ~clk;

    nand_tree_pipe #(.WIDTH(8), .INPUTS(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_op(a_in_op),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
    );

    nand_tree_pipe #(.WIDTH(8), .INPUTS(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_op(b_in_op),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_red(input logic [31:0] d, input logic [1:0] op);
        logic [7:0] r_and;
        logic [7:0] r_or;
        r_and = 8'hFF;
        r_or  = 8'h00;
        for (int i = 0; i < 4; i++) begin
            r_and = r_and & d[i*8 +: 8];
            r_or  = r_or  | d[i*8 +: 8];
        end
        case (op)
            OP_NAND: return ~r_and;
            OP_AND:  return r_and;
            OP_NOR:  return ~r_or;
            default: return r_or;
        endcase
    endfunction

    // Scoreboard for instance A: handshakes are sampled mid-cycle, ahead of the edge that commits them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_out_valid && a_out_ready) begin
                n_pop++;
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    check("sb_data", {24'h0, a_out_data}, {24'h0, sb_q.pop_front()});
                end
            end
            if (a_in_valid && a_in_ready) begin
                n_push++;
                sb_q.push_back(ref_red(a_in_data, a_in_op));
            end
        end
    end

    task automatic one_shot(input string tag, input logic [31:0] d, input logic [1:0] op, input logic [7:0] exp);
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = d;
        a_in_op     = op;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        check({tag, "_early"}, {31'h0, a_out_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_vld"}, {31'h0, a_out_valid}, 32'd1);
        check({tag, "_dat"}, {24'h0, a_out_data}, {24'h0, exp});
    endtask

    logic [7:0]  b_exp [4];
    logic [31:0] first_dat;
    logic [1:0]  first_op;
    int          push0;
    int          pop0;

    initial begin
        b_exp = '{8'hF7, 8'h08, 8'hF1, 8'h0E};

        // Reset values, both while held and just after release.
        #12;
        check("rst_vld", {31'h0, a_out_valid}, 32'd0);
        check("rst_dat", {24'h0, a_out_data}, 32'd0);
        check("rst_rdy", {31'h0, a_in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_vld", {31'h0, a_out_valid}, 32'd0);
        check("post_rst_rdy", {31'h0, a_in_ready}, 32'd1);

        one_shot("nand_all_ff", 32'hFFFF_FFFF, OP_NAND, 8'h00);
        one_shot("nand_one_0f", 32'hFFFF_0FFF, OP_NAND, 8'hF0);
        one_shot("nor_mix",     32'h0010_0001, OP_NOR,  8'hEE);

        // Two-operand instance, four ops back to back.
        @(posedge clk); #1;
        b_in_valid = 1'b1;
        b_in_data  = 16'h0A0C;
        b_in_op    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("b2_op%0d", i), {23'h0, b_out_valid, b_out_data}, {23'h0, 1'b1, b_exp[i]});
            if (i < 3) b_in_op = 2'(i + 1);
            else       b_in_valid = 1'b0;
        end

        // Streaming with out_ready held high.
        pop0 = n_pop;
        n_stall = 0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            a_in_valid = 1'b1;
            a_in_data  = $urandom;
            a_in_op    = 2'($urandom_range(0, 3));
            if (!a_in_ready) n_stall++;
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("stream_count", 32'(n_pop - pop0), 32'd32);
        check("stream_nostall", 32'(n_stall), 32'd0);

        // Backpressure: out_ready low for 5 cycles on continuous input.
        push0 = n_push;
        a_out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            a_in_valid = 1'b1;
            a_in_data  = $urandom;
            a_in_op    = 2'($urandom_range(0, 3));
            if (c == 0) begin
                first_dat = a_in_data;
                first_op  = a_in_op;
            end
        end
        @(posedge clk); #1;
        check("bp_accepts", 32'(n_push - push0), 32'd2);
        check("bp_in_rdy_low", {31'h0, a_in_ready}, 32'd0);
        check("bp_hold_vld", {31'h0, a_out_valid}, 32'd1);
        check("bp_hold_dat", {24'h0, a_out_data}, {24'h0, ref_red(first_dat, first_op)});
        a_out_ready = 1'b1;
        #1;
        check("bp_rdy_comb", {31'h0, a_in_ready}, 32'd1);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            a_in_data = $urandom;
            a_in_op   = 2'($urandom_range(0, 3));
        end

        // Random valid gaps and random backpressure.
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            a_in_valid  = 1'($urandom_range(0, 1));
            a_out_ready = 1'($urandom_range(0, 1));
            a_in_data   = $urandom;
            a_in_op     = 2'($urandom_range(0, 3));
        end
        @(posedge clk); #1;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        for (int c = 0; c < 20 && sb_q.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);
        check("push_eq_pop", 32'(n_push), 32'(n_pop));

        // Reset mid-flight with two beats in the tree.
        a_out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            a_in_valid = 1'b1;
            a_in_data  = $urandom;
            a_in_op    = 2'($urandom_range(0, 3));
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        check("mid_pre_vld", {31'h0, a_out_valid}, 32'd1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_vld", {31'h0, a_out_valid}, 32'd0);
        check("async_rst_dat", {24'h0, a_out_data}, 32'd0);
        check("async_rst_rdy", {31'h0, a_in_ready}, 32'd1);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("no_stale_%0d", c), {31'h0, a_out_valid}, 32'd0);
        end
        one_shot("post_mid_or", 32'h0102_0408, OP_OR, 8'h0F);
        @(posedge clk); #1;
        check("final_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
